// File: rtl/aes_pkg.sv
// Shared AES datapath types.
// State word width and selector mode encoding.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic {
    SEL_DIRECT = 1'b0,
    SEL_RR     = 1'b1
  } sel_mode_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int NUM_IN = 2,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W:0] j;

  // Scan in reverse so the last hit written is the first in scan order.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (SEL_W+1)'(k);
      if (j >= (SEL_W+1)'(NUM_IN))
        j = j - (SEL_W+1)'(NUM_IN);
      if (req[j[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = j[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/aes_state_sel.sv
// Registered N:1 AES state selector with valid/ready flow control.
// Direct select or round-robin arbitration among valid inputs.
module aes_state_sel
  import aes_pkg::*;
#(
  parameter int WIDTH  = AES_STATE_W,
  parameter int NUM_IN = 2,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    arb_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_ok;
  logic             load_en;
  logic             sel_ok;
  sel_mode_e        mode;
  logic [WIDTH-1:0] lanes [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign lanes[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign mode    = sel_mode_e'(arb_mode);
  assign load_en = !out_valid || out_ready;
  assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(NUM_IN))
                   && in_valid[sel];

  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    unique case (mode)
      SEL_DIRECT: begin
        gnt_ok  = sel_ok;
        gnt_idx = sel;
      end
      SEL_RR: begin
        gnt_ok  = rr_found;
        gnt_idx = rr_idx;
      end
    endcase
  end

  // No grants while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (!rst && load_en && gnt_ok)
      in_ready = NUM_IN'(1) << gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (gnt_ok) begin
        out_data  <= lanes[gnt_idx];
        out_src   <= gnt_idx;
        out_valid <= 1'b1;
        if (gnt_idx == SEL_W'(NUM_IN - 1))
          rr_ptr <= '0;
        else
          rr_ptr <= gnt_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_state_sel.sv
// Self-checking bench for aes_state_sel (NUM_IN=4 and NUM_IN=3).
// Reference model tracks register contents and rotation pointer as ints.
module tb_aes_state_sel;

  localparam int N = 4;
  localparam int W = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [1:0]     sel;
  logic           arb_mode;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_valid;
  logic           out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic           arb_mode3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_src3;
  logic           out_valid3;
  logic           out_ready3;

  int vectors = 0;
  int miscompares = 0;

  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;

  always #5 clk = ~clk;

  aes_state_sel #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .arb_mode  (arb_mode),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  aes_state_sel #(.WIDTH(W), .NUM_IN(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .arb_mode  (arb_mode3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rand_data();
    for (int c = 0; c < N; c++)
      in_data[c*W +: W] = rnd128();
  endtask

  // Channel granted this cycle, or -1 if none.
  function automatic int exp_grant();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (!arb_mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic cycle();
    bit ld;
    int g;
    ld = !m_valid || out_ready;
    g  = exp_grant();
    @(posedge clk);
    if (rst) begin
      m_valid = 0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*W +: W];
        m_src   = g;
        m_ptr   = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = '1; out_ready = 1; arb_mode = 0; sel = 0;
    rand_data();
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_ready got %b want 0000", in_ready);
      end
      cycle();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_out got v=%b d=%h s=%0d want 0/0/0",
                 out_valid, out_data, out_src);
      end
    end
    rst = 0;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_ready got %b want 0001", in_ready);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== in_data[W-1:0]) begin
      miscompares++;
      $display("FAIL first_load got v=%b d=%h want 1/%h",
               out_valid, out_data, in_data[W-1:0]);
    end
  endtask

  task automatic test_direct();
    logic [W-1:0] v;
    v = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    rand_data();
    in_data[2*W +: W] = v;
    arb_mode = 0; sel = 2; in_valid = 4'b1111; out_ready = 1;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL direct_ready got %b want 0100", in_ready);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== v || out_src !== 2'd2) begin
      miscompares++;
      $display("FAIL direct_out got v=%b d=%h s=%0d want 1/%h/2",
               out_valid, out_data, out_src, v);
    end
  endtask

  task automatic serve_direct(input int ch);
    arb_mode = 0; sel = 2'(ch); in_valid = N'(1) << ch; out_ready = 1;
    rand_data();
    cycle();
  endtask

  task automatic test_rr_fair();
    serve_direct(3);
    arb_mode = 1; in_valid = 4'b1111; out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      #1;
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || out_src !== 2'(k % 4)
          || out_data !== m_data) begin
        miscompares++;
        $display("FAIL rr_fair[%0d] got v=%b s=%0d d=%h want 1/%0d/%h",
                 k, out_valid, out_src, out_data, k % 4, m_data);
      end
    end
  endtask

  task automatic test_rr_skip();
    int want [3] = '{0, 2, 0};
    serve_direct(2);
    arb_mode = 1; in_valid = 4'b0101; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      #1;
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || out_src !== 2'(want[k])) begin
        miscompares++;
        $display("FAIL rr_skip[%0d] got v=%b s=%0d want 1/%0d",
                 k, out_valid, out_src, want[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hold;
    logic [1:0]   hsrc;
    serve_direct(1);
    hold = out_data; hsrc = out_src;
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'($urandom) | 4'b0001;
      arb_mode = 1'($urandom);
      sel = 2'($urandom);
      rand_data();
      #1;
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_ready[%0d] got %b want 0000", k, in_ready);
      end
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== hold || out_src !== hsrc) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b s=%0d d=%h want 1/%0d/%h",
                 k, out_valid, out_src, out_data, hsrc, hold);
      end
    end
    out_ready = 1; arb_mode = 1; in_valid = 4'b1111;
    rand_data();
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_release_ready got %b want 0100", in_ready);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== m_data) begin
      miscompares++;
      $display("FAIL bp_reload got v=%b s=%0d d=%h want 1/2/%h",
               out_valid, out_src, out_data, m_data);
    end
  endtask

  task automatic test_mode_switch();
    serve_direct(1);
    arb_mode = 1; in_valid = 4'b1111; out_ready = 1;
    rand_data();
    #1;
    cycle();
    vectors++;
    if (out_src !== 2'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_switch got v=%b s=%0d want 1/2", out_valid, out_src);
    end
  endtask

  task automatic test_rst_mid_stall();
    serve_direct(3);
    out_ready = 0; rst = 1;
    #1;
    cycle();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL rst_stall got v=%b d=%h want 0/0", out_valid, out_data);
    end
    rst = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      in_valid = 4'($urandom);
      sel = 2'($urandom);
      arb_mode = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      #1;
      er = exp_ready();
      vectors++;
      if (in_ready !== er) begin
        miscompares++;
        $display("FAIL rand_ready[%0d] got %b want %b", k, in_ready, er);
      end
      cycle();
      vectors++;
      if (out_valid !== m_valid
          || (m_valid && (out_data !== m_data || out_src !== m_src[1:0]))) begin
        miscompares++;
        $display("FAIL rand_out[%0d] got v=%b s=%0d d=%h want %b/%0d/%h",
                 k, out_valid, out_src, out_data, m_valid, m_src, m_data);
      end
    end
    rst = 0;
  endtask

  task automatic test_num3();
    logic [W-1:0] v;
    v = rnd128();
    in_data3 = {rnd128(), v, rnd128()};
    in_valid3 = 3'b111; arb_mode3 = 0; sel3 = 1; out_ready3 = 1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid3 !== 1'b1 || out_src3 !== 2'd1 || out_data3 !== v) begin
      miscompares++;
      $display("FAIL n3_load got v=%b s=%0d d=%h want 1/1/%h",
               out_valid3, out_src3, out_data3, v);
    end
    sel3 = 3;
    #1;
    vectors++;
    if (in_ready3 !== 3'b000) begin
      miscompares++;
      $display("FAIL n3_sel3_ready got %b want 000", in_ready3);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid3 !== 1'b0 || out_data3 !== v || out_src3 !== 2'd1) begin
      miscompares++;
      $display("FAIL n3_sel3_out got v=%b s=%0d d=%h want 0/1/%h",
               out_valid3, out_src3, out_data3, v);
    end
  endtask

  initial begin
    in_data3 = '0; in_valid3 = '0; sel3 = '0;
    arb_mode3 = 0; out_ready3 = 1;
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    test_reset();
    test_direct();
    test_rr_fair();
    test_rr_skip();
    test_backpressure();
    test_mode_switch();
    test_rst_mid_stall();
    test_random();
    test_num3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_state_sel.md
Name: aes_state_sel

Overview:
- Parametrised N:1 selector for AES 128-bit state words, registered and with valid/ready flow control.
- Successor to the plain 2:1 state mux. Selects among NUM_IN producers, e.g. plaintext load, round feedback and key-mixed state.
- Two modes: direct select (sel port), or round-robin arbitration among valid inputs.
- One output register gives one cycle of latency and full throughput of 1 word per cycle.

Parameters:
- WIDTH, 128, bits per state word.
- NUM_IN, 2, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN), derived localparam; width of sel and out_src. Not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; combinational, at most one bit set.
- sel  in  SEL_W  channel index used in direct mode.
- arb_mode  in  1  0 = direct select, 1 = round-robin.
- out_data  out  WIDTH  registered selected word.
- out_src  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready is all 0 in the reset cycle.
- Load enable: load_en = !out_valid || out_ready. The register accepts a new word when it is empty or is being drained in the same cycle.
- Candidate in direct mode: channel sel, only if sel < NUM_IN and in_valid[sel]=1. If sel >= NUM_IN there is no candidate; no error is flagged.
- Candidate in round-robin mode: the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping from NUM_IN-1 to 0.
- Grant: in_ready[g] = load_en && candidate exists && g == candidate. All other in_ready bits are 0.
  - in_ready depends combinationally on out_ready, in_valid, sel, arb_mode and rr_ptr.
  - There is no combinational path from in_data.
- Input transfer (in_valid[g] && in_ready[g]): on the next edge out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - rr_ptr <= g+1, wrapping to 0 after NUM_IN-1.
  - rr_ptr updates in both modes, so a later switch into round-robin starts after the last served channel.
- load_en with no candidate: out_valid <= 0. out_data and out_src hold their stale values.
- !load_en (out_valid=1, out_ready=0): out_data, out_src and out_valid hold. All in_ready bits are 0 and rr_ptr holds.
- Simultaneous drain and load: when out_ready=1 with a valid candidate, the old word leaves and the new word loads on the same edge. There is no bubble.
- Mode or sel change: takes effect on the next arbitration. The word already in the register is never altered.
- Input protocol: inputs must hold in_data and in_valid until accepted. The block does not check this.
- Reset mid-operation: rst has priority over all loads. A pending out_data word is discarded (out_valid=0 next cycle).
- Latency: 1 cycle from input handshake to out_valid.

Decomposition:
- Package aes_pkg holds:
  - AES_STATE_W = 128;
  - typedef logic [AES_STATE_W-1:0] aes_state_t;
  - typedef enum logic {SEL_DIRECT, SEL_RR} sel_mode_e.
- Sub-module rr_pick, purely combinational:
  - inputs: req [NUM_IN], ptr [SEL_W];
  - outputs: found, idx.
  - Reusable by a future key-schedule arbiter.
- Output register, load logic and rr_ptr remain in aes_state_sel.

Test Plan (NUM_IN=4, WIDTH=128 unless noted):
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000 throughout; first load occurs the cycle after rst falls.
- Direct mode: arb_mode=0, sel=2, in_valid=1111, in_data[2]=128'h00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 -> in_ready=0100; the next cycle out_valid=1, out_data equals that value, out_src=2.
- Round-robin fairness: arb_mode=1, all in_valid=1 held for 8 cycles, out_ready=1 -> out_src sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Round-robin skip and wrap: rr_ptr=3, in_valid=0101 -> grant 0, then 2, then 0.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles -> out_data and out_src stable and in_ready=0000; releasing out_ready gives a same-cycle drain and reload with no gap.
- Edges and corners:
  - NUM_IN=3, sel=3, arb_mode=0 -> no grant, out_valid falls to 0 after a drain.
  - Mode switch from 0 to 1 after serving channel 1 -> next grant is channel 2.
  - rst mid-stall -> out_valid=0 next cycle.
